// File: rtl/bist_ora_misr_if.sv
// Handshake/response bundle between the BIST controller, the full-adder CUT and the ORA.
// master: controller/CUT side driving responses; slave: the ORA itself.
interface bist_ora_misr_if #(
    parameter int unsigned WIDTH = 3
);
    logic             start;
    logic             resp_valid;
    logic             cut_sum;
    logic             cut_cout;
    logic [WIDTH-1:0] signature;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;

    modport master (
        output start, resp_valid, cut_sum, cut_cout,
        input  signature, busy, done, pass, fail, timeout
    );

    modport slave (
        input  start, resp_valid, cut_sum, cut_cout,
        output signature, busy, done, pass, fail, timeout
    );
endinterface

// File: rtl/bist_ora_misr.sv
// MISR-based output response analyser for the full-adder BIST chain.
// Optional watchdog enabled by defining BIST_ORA_TIMEOUT_EN.
module bist_ora_misr #(
    parameter int unsigned      WIDTH        = 3,
    parameter logic [WIDTH-1:0] POLY         = 3'b011,
    parameter logic [WIDTH-1:0] SEED         = 3'b000,
    parameter int unsigned      NUM_PATTERNS = 7,
    parameter logic [WIDTH-1:0] GOLDEN       = 3'b111,
    parameter int unsigned      TIMEOUT      = 15
) (
    input logic            clock,
    input logic            reset,
    bist_ora_misr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] misr_in;
    logic [WIDTH-1:0] misr_next;
    logic [7:0]       count;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             fail_q;

`ifdef BIST_ORA_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;
`endif

    // Galois MISR: stage 0 always takes the feedback bit, other stages per POLY.
    always_comb begin
        misr_in      = '0;
        misr_in[0]   = bus.cut_sum;
        misr_in[1]   = bus.cut_cout;
        misr_next    = '0;
        misr_next[0] = sig_q[WIDTH-1] ^ misr_in[0];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            misr_next[i] = sig_q[i-1] ^ (POLY[i] & sig_q[WIDTH-1]) ^ misr_in[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sig_q  <= SEED;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
`ifdef BIST_ORA_TIMEOUT_EN
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sig_q  <= SEED;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= CAPTURE;
`ifdef BIST_ORA_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                CAPTURE: begin
                    if (bus.resp_valid) begin
                        sig_q <= misr_next;
                        count <= count + 8'd1;
`ifdef BIST_ORA_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                        if (count == 8'(NUM_PATTERNS - 1)) begin
                            state <= COMPARE;
                        end
                    end
`ifdef BIST_ORA_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        fail_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                COMPARE: begin
                    pass_q <= (sig_q == GOLDEN);
                    fail_q <= (sig_q != GOLDEN);
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    if (bus.start) begin
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        sig_q  <= SEED;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= CAPTURE;
`ifdef BIST_ORA_TIMEOUT_EN
                        wd_cnt    <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.signature = sig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
`ifdef BIST_ORA_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif
endmodule
